// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the interrupt pending controller: FSM state encoding
// and the request-index width computation.
package irq_pending_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // A single line would give $clog2 = 0; keep the index at least one bit wide.
  function automatic int calc_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/mask inputs and valid/ack request channel of irq_pending_ctrl.
interface irq_pending_ctrl_if
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4
);
  localparam int ID_W = calc_id_w(N_IRQ);

  logic             en;
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             req_valid;
  logic [ID_W-1:0]  req_id;
  logic             req_ack;
  logic [N_IRQ-1:0] pending;

  // Environment side: drives requests, mask and ack.
  modport master (
    output en, irq_in, irq_mask, req_ack,
    input  req_valid, req_id, pending
  );

  // Controller side.
  modport slave (
    input  en, irq_in, irq_mask, req_ack,
    output req_valid, req_id, pending
  );

endinterface

// File: rtl/irq_pending_ctrl_prio_pick.sv
// Combinational priority picker: reports whether any eligible line exists and
// the highest set index.
module irq_prio_pick
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = calc_id_w(N_IRQ)
) (
  input  logic [N_IRQ-1:0] elig,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  assign any = |elig;

  // NOTE: idx gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    idx = '0;
    // Ascending scan: the last hit, i.e. the highest index, wins.
    for (int k = 0; k < N_IRQ; k++) begin
      if (elig[k]) idx = ID_W'(k);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending front-end: rising-edge capture into sticky pending bits,
// masked highest-index selection, and a valid/ack presentation FSM.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_ctrl_if.slave  bus
);

  localparam int ID_W = calc_id_w(N_IRQ);

  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] elig;
  logic             handshake;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;

  assign rise      = bus.irq_in & ~irq_prev;
  assign handshake = valid_q & bus.req_ack;
  assign clr       = handshake ? (N_IRQ'(1) << id_q) : '0;
  assign elig      = pending_q & bus.irq_mask;

  irq_prio_pick #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_pick (
    .elig (elig),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev  <= '0;
      pending_q <= '0;
    end else begin
      irq_prev  <= bus.irq_in;
      // Set is applied after clear, so a fresh edge on the acked line survives.
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (bus.en && pick_any) begin
          state_d = ST_PRESENT;
          valid_d = 1'b1;
          id_d    = pick_idx;
        end
      end
      ST_PRESENT: begin
        // id is frozen here; en, mask and pending changes are ignored.
        if (bus.req_ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign bus.req_valid = valid_q;
  assign bus.req_id    = id_q;
  assign bus.pending   = pending_q;

endmodule
